rvga_lsu: RTL and testbench

RVGA_LSU -- requirements
Module: rvga_lsu

---
 rtl/rvga_lsu.sv | 147 ++++++++++++++
 tb/tb_rvga_lsu.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvga_lsu.sv
// rvga_lsu: single-outstanding load/store unit.
// Aligns, masks and lane-shifts requests; extends load returns.
module rvga_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_v_i,
  output logic        req_ready_o,
  input  logic        req_ld_i,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        mem_v_o,
  input  logic        mem_ready_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rdata_v_i,
  input  logic [31:0] mem_rdata_i,
  output logic        resp_v_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic [4:0]  resp_rd_o,
  output logic        resp_err_o
);

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic        ld_q, err_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [4:0]  rd_q;

  logic        accept, req_err;
  logic        is_issue, is_resp;
  logic        sz_h, sz_w;
  logic [3:0]  be;
  logic [31:0] rsh, ld_ext;

  assign req_ready_o = rst_n & (state_q == IDLE);
  assign accept      = req_v_i & req_ready_o;
  assign is_issue    = (state_q == ISSUE);
  assign is_resp     = (state_q == RESP);

  always_comb begin
    req_err = 1'b0;
    unique case (req_op_i)
      OP_B:    req_err = 1'b0;
      OP_H:    req_err = req_addr_i[0];
      OP_W:    req_err = |req_addr_i[1:0];
      OP_BU:   req_err = ~req_ld_i;
      OP_HU:   req_err = ~req_ld_i | req_addr_i[0];
      default: req_err = 1'b1;
    endcase
  end

  // op[2] only marks unsigned loads; op[1:0] carries the size
  assign sz_h = (op_q[1:0] == 2'b01);
  assign sz_w = (op_q[1:0] == 2'b10);

  always_comb begin
    be = 4'b0001 << addr_q[1:0];
    unique case (1'b1)
      sz_w:    be = 4'b1111;
      sz_h:    be = 4'b0011 << addr_q[1:0];
      default: be = 4'b0001 << addr_q[1:0];
    endcase
  end

  assign rsh = mem_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_ext = rsh;
    unique case (op_q)
      OP_B:    ld_ext = {{24{rsh[7]}}, rsh[7:0]};
      OP_H:    ld_ext = {{16{rsh[15]}}, rsh[15:0]};
      OP_BU:   ld_ext = {24'h0, rsh[7:0]};
      OP_HU:   ld_ext = {16'h0, rsh[15:0]};
      default: ld_ext = rsh;
    endcase
  end

  assign mem_v_o     = is_issue;
  assign mem_we_o    = is_issue & ~ld_q;
  assign mem_addr_o  = is_issue ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_be_o    = is_issue ? be : 4'h0;
  assign mem_wdata_o = (!is_issue || ld_q) ? 32'h0 :
                       sz_w ? wdata_q :
                       wdata_q << {addr_q[1:0], 3'b000};

  assign resp_v_o    = is_resp;
  assign resp_data_o = is_resp ? data_q : 32'h0;
  assign resp_rd_o   = (is_resp & ld_q) ? rd_q : 5'h0;
  assign resp_err_o  = is_resp & err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = req_err ? RESP : ISSUE;
      ISSUE:   if (mem_ready_i) state_d = ld_q ? WAIT : RESP;
      WAIT:    if (mem_rdata_v_i) state_d = RESP;
      RESP:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_q    <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= 3'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rd_q    <= 5'h0;
      data_q  <= 32'h0;
    end else if (accept) begin
      ld_q    <= req_ld_i;
      err_q   <= req_err;
      op_q    <= req_op_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
      rd_q    <= req_rd_i;
      data_q  <= 32'h0;
    end else if (state_q == WAIT && mem_rdata_v_i) begin
      data_q  <= ld_ext;
    end
  end

endmodule

// File: tb/tb_rvga_lsu.sv
// tb_rvga_lsu: directed vectors with a queue scoreboard
// for memory commands and writeback responses.
module tb_rvga_lsu;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_cmd_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } resp_t;

  logic        clk, rst_n;
  logic        req_v_i, req_ready_o, req_ld_i;
  logic [2:0]  req_op_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        mem_v_o, mem_ready_i, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_rdata_v_i;
  logic [31:0] mem_rdata_i;
  logic        resp_v_o, resp_ready_i, resp_err_o;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_rd_o;

  rvga_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_v_i(req_v_i), .req_ready_o(req_ready_o),
    .req_ld_i(req_ld_i), .req_op_i(req_op_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_rd_i(req_rd_i),
    .mem_v_o(mem_v_o), .mem_ready_i(mem_ready_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_v_i(mem_rdata_v_i), .mem_rdata_i(mem_rdata_i),
    .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_rd_o(resp_rd_o),
    .resp_err_o(resp_err_o)
  );

  int checks = 0;
  int errors = 0;

  mem_cmd_t exp_mem[$];
  resp_t    exp_resp[$];

  logic [31:0] mem_word = 32'h0;
  int mem_stall  = 0;
  int resp_stall = 0;
  int mem_lat    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory model: optional stall before ready, load data after mem_lat
  initial begin
    int pend;
    pend = -1;
    mem_ready_i   = 1'b1;
    mem_rdata_v_i = 1'b0;
    mem_rdata_i   = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_v_o && mem_ready_i && !mem_we_o) pend = mem_lat;
      @(posedge clk);
      #1;
      if (pend == 0) begin
        mem_rdata_v_i = 1'b1;
        mem_rdata_i   = mem_word;
        pend = -1;
      end else begin
        mem_rdata_v_i = 1'b0;
        mem_rdata_i   = 32'h0;
        if (pend > 0) pend--;
      end
      if (mem_v_o && mem_stall > 0) begin
        mem_ready_i = 1'b0;
        mem_stall--;
      end else begin
        mem_ready_i = 1'b1;
      end
    end
  end

  initial begin
    resp_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (resp_v_o && resp_stall > 0) begin
        resp_ready_i = 1'b0;
        resp_stall--;
      end else begin
        resp_ready_i = 1'b1;
      end
    end
  end

  // monitor: every valid cycle must match the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_v_o) begin
        if (exp_mem.size() == 0) begin
          chk("mem_unexpected", 64'(mem_v_o), 64'd0);
        end else begin
          chk("mem_cmd",
              64'({mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}),
              64'(exp_mem[0]));
          if (mem_ready_i) void'(exp_mem.pop_front());
        end
      end
      if (resp_v_o) begin
        if (exp_resp.size() == 0) begin
          chk("resp_unexpected", 64'(resp_v_o), 64'd0);
        end else begin
          chk("resp",
              64'({resp_data_o, resp_rd_o, resp_err_o}),
              64'(exp_resp[0]));
          if (resp_ready_i) void'(exp_resp.pop_front());
        end
      end
    end
  end

  task automatic issue(input bit ld, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd,
                       input bit has_cmd, input mem_cmd_t c,
                       input bit has_resp, input resp_t r,
                       input int lat);
    int n;
    if (has_cmd)  exp_mem.push_back(c);
    if (has_resp) exp_resp.push_back(r);
    @(posedge clk);
    #1;
    req_v_i = 1'b1;
    req_ld_i = ld;
    req_op_i = op;
    req_addr_i = addr;
    req_wdata_i = wdata;
    req_rd_i = rd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready_o && n < 50);
    if (!req_ready_o) begin
      chk("accept_timeout", 64'(req_ready_o), 64'd1);
      req_v_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_v_i = 1'b0;
    if (!has_resp) return;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_v_o && n < 100);
    if (lat >= 0) chk("latency", 64'(n), 64'(lat));
    n = 0;
    while (exp_resp.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("resp_drain", 64'(exp_resp.size()), 64'd0);
  endtask

  function automatic mem_cmd_t mc(input logic we, input logic [31:0] a,
                                  input logic [3:0] be,
                                  input logic [31:0] wd);
    mem_cmd_t m;
    m.we = we;
    m.addr = a;
    m.be = be;
    m.wdata = wd;
    return m;
  endfunction

  function automatic resp_t rs(input logic [31:0] d, input logic [4:0] rd,
                               input logic err);
    resp_t x;
    x.data = d;
    x.rd = rd;
    x.err = err;
    return x;
  endfunction

  function automatic logic [79:0] all_outs();
    return {req_ready_o, mem_v_o, mem_we_o, resp_v_o, resp_err_o,
            mem_be_o, mem_addr_o, mem_wdata_o, resp_data_o, resp_rd_o};
  endfunction

  mem_cmd_t nc;

  initial begin
    nc = '0;
    rst_n = 1'b0;
    req_v_i = 1'b0;
    req_ld_i = 1'b0;
    req_op_i = 3'h0;
    req_addr_i = 32'h0;
    req_wdata_i = 32'h0;
    req_rd_i = 5'h0;
    #3;
    chk("reset_outs", 64'(all_outs() != 0), 64'd0);
    @(posedge clk);
    #1;
    chk("reset_outs_clk", 64'(all_outs() != 0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready_o), 64'd1);

    mem_word = 32'h80112233;
    issue(1, 3'b000, 32'h103, 0, 5'd5, 1, mc(0, 32'h100, 4'b1000, 0),
          1, rs(32'hFFFFFF80, 5'd5, 0), 3);
    issue(0, 3'b001, 32'h202, 32'h0000BEEF, 5'd7,
          1, mc(1, 32'h200, 4'b1100, 32'hBEEF0000),
          1, rs(0, 0, 0), 2);
    issue(1, 3'b010, 32'h101, 0, 5'd3, 0, nc, 1, rs(0, 5'd3, 1), 1);

    mem_word = 32'hABCD1234;
    mem_stall = 3;
    resp_stall = 2;
    issue(1, 3'b101, 32'h2, 0, 5'd9, 1, mc(0, 32'h0, 4'b1100, 0),
          1, rs(32'h0000ABCD, 5'd9, 0), -1);
    chk("mem_stall_used", 64'(mem_stall), 64'd0);
    chk("resp_stall_used", 64'(resp_stall), 64'd0);

    issue(1, 3'b011, 32'h0, 0, 5'd2, 0, nc, 1, rs(0, 5'd2, 1), 1);
    issue(1, 3'b110, 32'h0, 0, 5'd2, 0, nc, 1, rs(0, 5'd2, 1), 1);
    issue(1, 3'b001, 32'h1, 0, 5'd4, 0, nc, 1, rs(0, 5'd4, 1), 1);
    issue(0, 3'b011, 32'h0, 32'h1, 5'd1, 0, nc, 1, rs(0, 0, 1), 1);
    issue(0, 3'b001, 32'h203, 32'h1, 5'd1, 0, nc, 1, rs(0, 0, 1), 1);
    issue(0, 3'b010, 32'h402, 32'h1, 5'd1, 0, nc, 1, rs(0, 0, 1), 1);

    mem_word = 32'h80112233;
    issue(1, 3'b100, 32'h101, 0, 5'd6, 1, mc(0, 32'h100, 4'b0010, 0),
          1, rs(32'h00000022, 5'd6, 0), 3);
    mem_word = 32'h1234F00D;
    issue(1, 3'b001, 32'h0, 0, 5'd8, 1, mc(0, 32'h0, 4'b0011, 0),
          1, rs(32'hFFFFF00D, 5'd8, 0), 3);
    mem_word = 32'hDEADBEEF;
    issue(1, 3'b010, 32'h104, 0, 5'd31, 1, mc(0, 32'h104, 4'b1111, 0),
          1, rs(32'hDEADBEEF, 5'd31, 0), 3);
    issue(0, 3'b000, 32'h301, 32'h123456A5, 5'd1,
          1, mc(1, 32'h300, 4'b0010, 32'h3456A500),
          1, rs(0, 0, 0), 2);
    issue(0, 3'b010, 32'h400, 32'hCAFEF00D, 5'd1,
          1, mc(1, 32'h400, 4'b1111, 32'hCAFEF00D),
          1, rs(0, 0, 0), 2);

    // reset during WAIT, memory answers after release
    mem_lat = 3;
    mem_word = 32'h55555555;
    issue(1, 3'b010, 32'h10, 0, 5'd4, 1, mc(0, 32'h10, 4'b1111, 0),
          0, rs(0, 0, 0), -1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("mid_reset_outs", 64'(all_outs() != 0), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_lat = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_after_reset", 64'({req_ready_o, resp_v_o, mem_v_o}),
          64'b100);
    end

    mem_word = 32'h000000F0;
    issue(1, 3'b000, 32'h20, 0, 5'd12, 1, mc(0, 32'h20, 4'b0001, 0),
          1, rs(32'hFFFFFFF0, 5'd12, 0), 3);

    repeat (3) @(negedge clk);
    chk("mem_queue_empty", 64'(exp_mem.size()), 64'd0);
    chk("resp_queue_empty", 64'(exp_resp.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
